// File: rtl/mem_resp_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states,
// response error codes and small byte-lane helpers.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
    logic mis;
    case (sz)
      SZ_BYTE:   mis = 1'b0;
      SZ_HALF:   mis = off[0];
      SZ_WORD:   mis = |off[1:0];
      SZ_DOUBLE: mis = |off;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte enables within the doubleword; only meaningful for aligned accesses.
  function automatic logic [7:0] lane_mask(input size_e sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      SZ_BYTE:   m = 8'h01;
      SZ_HALF:   m = 8'h03;
      SZ_WORD:   m = 8'h0F;
      SZ_DOUBLE: m = 8'hFF;
      default:   m = 8'h00;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Extracts the addressed byte lanes of a doubleword, right-justifies them and
// applies zero or sign extension.
module load_align_ext
  import mem_resp_pkg::*;
(
  input  logic [63:0] i_dw,
  input  logic [2:0]  i_off,
  input  size_e       i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic [63:0] w_sh;

  assign w_sh = i_dw >> {i_off, 3'b000};

  // Size-dependent extension of the right-justified lanes
  always_comb begin
    o_data = 64'd0;
    case (i_size)
      SZ_BYTE:   o_data = {{56{~i_unsigned & w_sh[7]}},  w_sh[7:0]};
      SZ_HALF:   o_data = {{48{~i_unsigned & w_sh[15]}}, w_sh[15:0]};
      SZ_WORD:   o_data = {{32{~i_unsigned & w_sh[31]}}, w_sh[31:0]};
      SZ_DOUBLE: o_data = w_sh;
      default:   o_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a doubleword array with
// alignment and range checking and a read-modify-write store path.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [63:0] RSP_RDATA,
  output logic [1:0]  RSP_ERR
);

  logic [63:0] r_mem [DEPTH];

  state_e      r_state, w_next;
  logic        r_we, r_uns;
  size_e       r_size;
  logic [2:0]  r_off;
  logic [AW-1:0] r_idx;
  logic [63:0] r_wdata, r_hold, r_rdata;
  logic [1:0]  r_err;

  logic        w_accept, w_oor;
  logic [1:0]  w_req_err;
  logic [63:0] w_rd_dw, w_ext, w_bmask, w_wsh, w_merged;
  logic [7:0]  w_lanes;

  assign REQ_READY = (r_state == ST_IDLE);
  assign RSP_VALID = (r_state == ST_RESP);
  assign RSP_RDATA = r_rdata;
  assign RSP_ERR   = r_err;

  assign w_accept = REQ_VALID && (r_state == ST_IDLE);
  assign w_oor    = |(REQ_ADDR >> (AW + 3));
  assign w_rd_dw  = r_mem[r_idx];

  // Request classification: misalignment takes priority over range
  always_comb begin
    w_req_err = ERR_OK;
    if (is_misaligned(size_e'(REQ_SIZE), REQ_ADDR[2:0])) begin
      w_req_err = ERR_MISALIGN;
    end else if (w_oor) begin
      w_req_err = ERR_RANGE;
    end else begin
      w_req_err = ERR_OK;
    end
  end

  load_align_ext u_ext (
    .i_dw       (w_rd_dw),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

  // Store merge: new lanes from shifted write data, the rest from the held word
  always_comb begin
    w_lanes = lane_mask(r_size, r_off);
    w_bmask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      w_bmask[i*8 +: 8] = {8{w_lanes[i]}};
    end
    w_wsh    = r_wdata << {r_off, 3'b000};
    w_merged = (r_hold & ~w_bmask) | (w_wsh & w_bmask);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (w_req_err != ERR_OK) ? ST_RESP : ST_READ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP: begin
        if (RSP_READY) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, latched request fields and response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= SZ_BYTE;
      r_off   <= 3'd0;
      r_idx   <= '0;
      r_wdata <= 64'd0;
      r_hold  <= 64'd0;
      r_rdata <= 64'd0;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= REQ_WE;
        r_uns   <= REQ_UNSIGNED;
        r_size  <= size_e'(REQ_SIZE);
        r_off   <= REQ_ADDR[2:0];
        r_idx   <= REQ_ADDR[AW+2:3];
        r_wdata <= REQ_WDATA;
        r_rdata <= 64'd0;
        r_err   <= w_req_err;
      end
      if (r_state == ST_READ) begin
        r_hold  <= w_rd_dw;
        r_rdata <= r_we ? 64'd0 : w_ext;
      end
    end
  end

  // Storage write-back; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (r_state == ST_WRITE) begin
      r_mem[r_idx] <= w_merged;
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 64-bit doublewords stored (power of two, at least 2).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning the doubleword index width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 REQ_VALID  input  1  initiator presents a request.
REQ-007 REQ_READY  output  1  responder can accept a request.
REQ-008 REQ_WE  input  1  1 = store, 0 = load.
REQ-009 REQ_SIZE  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-010 REQ_UNSIGNED  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-011 REQ_ADDR  input  64  byte address.
REQ-012 REQ_WDATA  input  64  store data, right-justified.
REQ-013 RSP_VALID  output  1  response present.
REQ-014 RSP_READY  input  1  initiator accepts the response.
REQ-015 RSP_RDATA  output  64  extended load data; 0 for stores and for errors.
REQ-016 RSP_ERR  output  2  00 ok, 01 misaligned, 10 out of range.

Function
REQ-017 SHALL accept a request on a rising edge where REQ_VALID and REQ_READY are both 1, and SHALL latch all REQ_* fields on that edge.
REQ-018 REQ_READY SHALL be 1 only in state IDLE, so at most one request is outstanding.
REQ-019 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-020 On acceptance, misalignment SHALL be checked first: REQ_ADDR modulo (1<<REQ_SIZE) not equal to 0 SHALL give error 01.
REQ-021 If the access is aligned, REQ_ADDR >= DEPTH*8 SHALL give error 10.
REQ-022 An errored request SHALL go IDLE -> RESP directly, with RSP_RDATA = 0 and no storage change.
REQ-023 A valid request SHALL go IDLE -> READ; READ SHALL perform a synchronous read of the doubleword at REQ_ADDR[AW+2:3] into a holding register.
REQ-024 For a load, READ -> RESP; RSP_RDATA SHALL be the addressed byte lanes (offset REQ_ADDR[2:0]) shifted to bit 0 and extended per REQ_UNSIGNED.
REQ-025 For a store, READ -> WRITE; WRITE SHALL merge REQ_WDATA's low (8<<REQ_SIZE) bits into the addressed lanes of the held doubleword, write it back, preserve all other lanes, and then go to RESP.
REQ-026 Latency from the acceptance edge to the first cycle with RSP_VALID = 1 SHALL be 1 cycle for an error, 2 for a load and 3 for a store.
REQ-027 In RESP, RSP_VALID SHALL be 1, and RSP_RDATA and RSP_ERR SHALL be held stable until the edge where RSP_READY = 1, which SHALL return the FSM to IDLE.
REQ-028 A new request SHALL NOT be accepted on the same edge that completes a response; the earliest acceptance is on the following edge.
REQ-029 A load issued after a store to the same doubleword SHALL return the post-store data.
REQ-030 A double access at 8*(DEPTH-1) SHALL be legal; 8*DEPTH SHALL give error 10.

Reset
REQ-031 On RST = 0, the state SHALL become IDLE, REQ_READY SHALL be 1, RSP_VALID SHALL be 0, RSP_RDATA SHALL be 0 and RSP_ERR SHALL be 00, all asynchronously.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 A reset asserted before the WRITE edge SHALL abort the request with the stored doubleword left unchanged; no response SHALL follow.

Structure
REQ-034 Package mem_resp_pkg SHALL hold the size encodings, the FSM state enum and the error codes.
REQ-035 Combinational lane extraction and sign/zero extension SHALL be the sub-module load_align_ext (inputs doubleword, offset, size, unsigned; output 64 bits).
REQ-036 Store lane merging SHALL be inline in data_mem_responder.
REQ-037 The storage SHALL be a single-port array in data_mem_responder, with the read in READ and the write in WRITE.

Verification
REQ-038 Store double 0x8877665544332211 @0x10, then load byte signed @0x17 -> RSP_RDATA = 0xFFFFFFFFFFFFFF88, RSP_ERR = 00, RSP_VALID 2 cycles after acceptance.
REQ-039 Then store half 0xBEEF @0x12, then load double @0x10 -> 0x88776655BEEF2211; store response 3 cycles after acceptance.
REQ-040 Load word unsigned @0x14 after REQ-039 -> 0x0000000088776655; load word signed -> 0xFFFFFFFF88776655.
REQ-041 Load half @0x13 -> RSP_ERR = 01 after 1 cycle; load double @0x800 (DEPTH 256) -> RSP_ERR = 10; load double @0x7F8 -> RSP_ERR = 00; storage unchanged.
REQ-042 RSP_READY held 0 for 5 cycles -> RSP_VALID and RSP_RDATA stable throughout; REQ_VALID held 1 -> no acceptance until the edge after the response completes.
REQ-043 Store double 0xAA @0x20, then assert RST during READ -> REQ_READY = 1 immediately, no response, and a later load @0x20 returns the prior value.
